frequency_generator: RTL
========================

Name: frequency_generator

Overview:
Programmable square-wave source: the transmit-side counterpart of the frequency counter.
- Produces signal_out with a period set in clock cycles, either continuously or for a fixed burst count.
- The bench or a second tile feeds signal_out into the frequency counter for loop-back checks.
- Control inputs come from switches and are synchronised internally.

Parameters:
- HALF_W, 16, width of half-period value in clock cycles.
- DEFAULT_HALF, 16'd5, active half-period after reset.
- BURST_W, 8, width of burst length.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- enable  input  1  asynchronous run request from switch; level-sensitive.
- load  input  1  asynchronous load strobe from switch; acts on its rising edge.
- half_period_in  input  HALF_W  requested half-period in clk cycles; sampled on load.
- burst_len  input  BURST_W  full cycles per run; 0 = continuous; sampled on IDLE->RUN.
- signal_out  output  1  generated square wave.
- busy  output  1  high when state != IDLE.
- done  output  1  high in DONE.
- dbg_state  output  2  IDLE=0, RUN=1, STOP=2, DONE=3.

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Reset:
- signal_out=0, busy=0, done=0, dbg_state=0.
- Counters 0, active_half=DEFAULT_HALF, pending_valid=0, sync flops 0.
- Reset asserted mid-run forces signal_out low immediately, without waiting for clk.

Synchronisation:
- enable and load each pass through 2 flops.
- load_pulse = synced load high AND previous synced value low; one cycle wide.

Load path:
- On load_pulse: pending_half <= max(half_period_in, 1); pending_valid <= 1.
- A value of 0 is clamped to 1, giving a 2-cycle period (clk/2).
- In IDLE or DONE, pending is copied to active_half on the next cycle.
- In RUN/STOP, pending is copied only at a toggle point, so no phase is truncated or runt.
- load_pulse and toggle in the same cycle: toggle consumes the prior pending value (if valid); the new value is stored in pending and pending_valid stays 1.

Waveform:
- Phase counter counts 0..active_half-1.
- At active_half-1, signal_out inverts and the counter returns to 0 (toggle point).
- Period = 2*active_half cycles, 50% duty.

State machine:
- IDLE:
  - signal_out=0.
  - If synced enable=1: go RUN; on the same edge set signal_out=1, phase counter=0, latch burst_len, cycle count=0.
  - Rising edge on the enable pin to first signal_out high: 3 clk edges.
- RUN:
  - Toggle as above.
  - Each falling toggle (1->0) increments cycle count.
  - If latched burst_len != 0 and the incremented count == burst_len: go DONE (signal_out low).
  - Else if synced enable=0: go STOP.
  - Burst completion takes precedence over enable drop in the same cycle.
- STOP:
  - If signal_out=0: go IDLE next cycle.
  - If signal_out=1: finish the current high phase, drive low at the toggle point, then go IDLE.
  - Enable re-asserted during STOP is ignored until IDLE is reached.
- DONE:
  - signal_out=0, done=1.
  - Stay until synced enable=0, then go IDLE.
- Cycle count saturates at its maximum width; continuous mode never reaches DONE.

Outputs:
- All outputs are registered.

Test Plan:
1. Reset, DEFAULT_HALF=5, burst_len=0; raise enable -> first signal_out rise 3 cycles later, then exactly 5 high / 5 low repeating; busy=1, dbg_state=1.
2. Running with half=5; load half_period_in=3 mid high phase -> current high phase lasts the full 5 cycles, all following phases 3 cycles; no phase shorter than 3.
3. Load half_period_in=0, enable -> signal_out toggles every cycle (period 2).
4. half=2, burst_len=4, enable held -> exactly 4 high pulses (2 cycles each), then signal_out=0, done=1, dbg_state=3; drop enable -> done=0, busy=0, dbg_state=0.
5. half=10; drop enable 3 cycles into a high phase -> high phase still lasts 10 cycles, then low; busy falls one cycle after the falling toggle; no further pulses.
6. Assert rst_n low mid high phase -> signal_out=0 before the next clk edge, dbg_state=0; after release and enable, period is back to 10 cycles (DEFAULT_HALF).

Source files
------------

// File: rtl/frequency_generator_if.sv
// ============================================================================
// frequency_generator_if : control/status bundle of the square-wave generator
// Rev 1.0
// ============================================================================
`default_nettype none

interface frequency_generator_if #(
    parameter int unsigned HALF_W  = 16,
    parameter int unsigned BURST_W = 8
) ();
    logic               enable;
    logic               load;
    logic [HALF_W-1:0]  half_period_in;
    logic [BURST_W-1:0] burst_len;
    logic               signal_out;
    logic               busy;
    logic               done;
    logic [1:0]         dbg_state;

    modport master (
        output enable, load, half_period_in, burst_len,
        input  signal_out, busy, done, dbg_state
    );

    modport slave (
        input  enable, load, half_period_in, burst_len,
        output signal_out, busy, done, dbg_state
    );
endinterface

`default_nettype wire

// File: rtl/frequency_generator.sv
// ============================================================================
// frequency_generator : programmable 50% square wave, continuous or burst
// Rev 1.0
// ============================================================================
`default_nettype none

module frequency_generator #(
    parameter int unsigned       HALF_W       = 16,
    parameter logic [HALF_W-1:0] DEFAULT_HALF = 16'd5,
    parameter int unsigned       BURST_W      = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    frequency_generator_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [HALF_W-1:0]  c_HALF_ONE = {{(HALF_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] c_CYC_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_nx;
    logic               r_en_s1, r_en_s2;
    logic               r_ld_s1, r_ld_s2, r_ld_s3;
    logic [HALF_W-1:0]  r_phase, w_phase_nx;
    logic [HALF_W-1:0]  r_active, r_pending;
    logic               r_pending_valid;
    logic [BURST_W-1:0] r_burst, w_burst_nx;
    logic [BURST_W-1:0] r_cycles, w_cycles_nx;
    logic               r_sig, w_sig_nx;
    logic               r_busy, r_done;
    logic               w_swap;

    logic               w_load_pulse;
    logic [HALF_W-1:0]  w_load_val;
    logic               w_toggle;
    logic [BURST_W-1:0] w_cyc_inc;
    logic               w_burst_hit;

    assign w_load_pulse = r_ld_s2 & ~r_ld_s3;
    assign w_load_val   = (bus.half_period_in == '0) ? c_HALF_ONE : bus.half_period_in;
    assign w_toggle     = (r_phase == (r_active - c_HALF_ONE));
    assign w_cyc_inc    = (r_cycles == '1) ? r_cycles : (r_cycles + c_CYC_ONE);
    assign w_burst_hit  = r_sig && w_toggle && (r_burst != '0) && (w_cyc_inc == r_burst);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // w_swap marks the edges at which a pending half-period may become active
    always_comb begin
        w_state_nx  = r_state;
        w_sig_nx    = r_sig;
        w_phase_nx  = r_phase;
        w_cycles_nx = r_cycles;
        w_burst_nx  = r_burst;
        w_swap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sig_nx   = 1'b0;
                w_phase_nx = '0;
                w_swap     = 1'b1;
                if (r_en_s2) begin
                    w_state_nx  = S_RUN;
                    w_sig_nx    = 1'b1;
                    w_burst_nx  = bus.burst_len;
                    w_cycles_nx = '0;
                end
            end
            S_RUN: begin
                if (w_toggle) begin
                    w_sig_nx   = ~r_sig;
                    w_phase_nx = '0;
                    w_swap     = 1'b1;
                    if (r_sig) begin
                        w_cycles_nx = w_cyc_inc;
                    end
                end else begin
                    w_phase_nx = r_phase + c_HALF_ONE;
                end
                if (w_burst_hit) begin
                    w_state_nx = S_DONE;
                    w_sig_nx   = 1'b0;
                end else if (!r_en_s2) begin
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (!r_sig) begin
                    w_state_nx = S_IDLE;
                    w_phase_nx = '0;
                end else if (w_toggle) begin
                    w_sig_nx   = 1'b0;
                    w_phase_nx = '0;
                    w_swap     = 1'b1;
                end else begin
                    w_phase_nx = r_phase + c_HALF_ONE;
                end
            end
            default: begin
                w_sig_nx = 1'b0;
                w_swap   = 1'b1;
                if (!r_en_s2) begin
                    w_state_nx = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_s1         <= 1'b0;
            r_en_s2         <= 1'b0;
            r_ld_s1         <= 1'b0;
            r_ld_s2         <= 1'b0;
            r_ld_s3         <= 1'b0;
            r_phase         <= '0;
            r_active        <= DEFAULT_HALF;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_burst         <= '0;
            r_cycles        <= '0;
            r_sig           <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_en_s1  <= bus.enable;
            r_en_s2  <= r_en_s1;
            r_ld_s1  <= bus.load;
            r_ld_s2  <= r_ld_s1;
            r_ld_s3  <= r_ld_s2;
            r_phase  <= w_phase_nx;
            r_burst  <= w_burst_nx;
            r_cycles <= w_cycles_nx;
            r_sig    <= w_sig_nx;
            r_busy   <= (w_state_nx != S_IDLE);
            r_done   <= (w_state_nx == S_DONE);
            // A new load in a swap cycle keeps pending valid; the old value is consumed
            if (w_swap && r_pending_valid) begin
                r_active <= r_pending;
            end
            if (w_load_pulse) begin
                r_pending       <= w_load_val;
                r_pending_valid <= 1'b1;
            end else if (w_swap) begin
                r_pending_valid <= 1'b0;
            end
        end
    end

    assign bus.signal_out = r_sig;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.dbg_state  = r_state;

endmodule

`default_nettype wire
